// File: rtl/pwm_seq_pkg.sv
// pwm_seq_pkg: shared types and widths for the PWM profile sequencer
package pwm_seq_pkg;

    typedef enum logic {IDLE, RUN} fsm_t;

    localparam int STATE_W = 3;
    localparam int DUTY_W = 12;
    localparam logic [STATE_W-1:0] LAST_STATE = 3'd5;
    localparam int STATE_COUNT = 6;

endpackage

// File: rtl/pwm_sequencer_lookup.sv
// pwm_state_lookup: maps a profile state to its target duty and whether it ramps
module pwm_state_lookup
    import pwm_seq_pkg::*;
#(
    parameter int PERIOD = 1200
) (
    input  logic [STATE_W-1:0] state,
    output logic [DUTY_W-1:0]  base_duty,
    output logic               ramp_enable
);

    // Profile: off, off, ramp-up to full, full, full, ramp-down to off
    always_comb begin
        base_duty = (state >= 3'd2 && state <= 3'd4) ? DUTY_W'(PERIOD) : '0;
        ramp_enable = (state == 3'd2) || (state == LAST_STATE);
    end

endmodule

// File: rtl/pwm_sequencer.sv
// pwm_sequencer: steps the six-state PWM profile, owning period counter, ramped duty and pin
module pwm_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int PERIOD = 1200,
    parameter int DWELL_PERIODS = 50,
    parameter int RAMP_STEP = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               start,
    input  logic               abort,
    input  logic               loop,
    output logic [STATE_W-1:0] state,
    output logic [DUTY_W-1:0]  duty,
    output logic               pwm_out,
    output logic               period_tick,
    output logic               busy,
    output logic               done
);

    localparam int DW = DWELL_PERIODS > 1 ? $clog2(DWELL_PERIODS) : 1;
    localparam int RW = DUTY_W + 1;
    localparam logic [DUTY_W-1:0] LAST_CNT = DUTY_W'(PERIOD - 1);
    localparam logic [DW-1:0] LAST_DWELL = DW'(DWELL_PERIODS - 1);
    localparam logic [RW-1:0] STEP = RW'(RAMP_STEP);

    fsm_t               fsm_q, fsm_d;
    logic [DUTY_W-1:0]  cnt_q, cnt_d, duty_q, duty_d;
    logic [DW-1:0]      dwell_q, dwell_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic               pwm_out_q, pwm_out_d, done_q, done_d;
    logic [DUTY_W-1:0]  base_duty, ramped;
    logic               ramp_enable, run, tick, last_dwell;
    logic [RW-1:0]      up, dn;

    pwm_state_lookup #(.PERIOD(PERIOD)) u_lookup (
        .state      (state_q),
        .base_duty  (base_duty),
        .ramp_enable(ramp_enable)
    );

    // Next duty at a tick: ramp one step toward the target in 13 bits, clamping at the target
    always_comb begin
        run = fsm_q == RUN;
        tick = run && enable && cnt_q == LAST_CNT;
        last_dwell = dwell_q == LAST_DWELL;
        up = {1'b0, duty_q} + STEP;
        dn = {1'b0, duty_q} - STEP;
        ramped = !ramp_enable ? base_duty
               : duty_q < base_duty ? (up >= {1'b0, base_duty} ? base_duty : up[DUTY_W-1:0])
               : (dn[DUTY_W] || dn[DUTY_W-1:0] <= base_duty) ? base_duty : dn[DUTY_W-1:0];
    end

    // FSM, period/dwell counters and duty update; pwm is precomputed from next-state values
    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        dwell_d = dwell_q;
        state_d = state_q;
        duty_d = duty_q;
        done_d = 1'b0;
        if (abort || !run) begin
            fsm_d = (!abort && start) ? RUN : IDLE;
            cnt_d = '0;
            dwell_d = '0;
            state_d = '0;
            duty_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                duty_d = ramped;
                dwell_d = last_dwell ? '0 : dwell_q + 1'b1;
                if (last_dwell) begin
                    if (state_q != LAST_STATE) begin
                        state_d = state_q + 1'b1;
                    end else if (loop) begin
                        state_d = '0;
                    end else begin
                        fsm_d = IDLE;
                        state_d = '0;
                        duty_d = '0;
                        done_d = 1'b1;
                    end
                end
            end
        end
        pwm_out_d = fsm_d == RUN && enable && cnt_d < duty_d;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
            cnt_q <= '0;
            dwell_q <= '0;
            state_q <= '0;
            duty_q <= '0;
            pwm_out_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
            dwell_q <= dwell_d;
            state_q <= state_d;
            duty_q <= duty_d;
            pwm_out_q <= pwm_out_d;
            done_q <= done_d;
        end
    end

    assign state = state_q;
    assign duty = duty_q;
    assign pwm_out = pwm_out_q;
    assign period_tick = tick;
    assign busy = run;
    assign done = done_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// tb_pwm_sequencer: randomized scoreboard bench against a behavioural profile model
module tb_pwm_sequencer;

    localparam int P = 40;
    localparam int D = 5;
    localparam int S = 9;
    localparam int SEQ = 6 * D * P;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        loop = 1'b0;
    logic [2:0]  state;
    logic [11:0] duty;
    logic        pwm_out, period_tick, busy, done;

    pwm_sequencer #(.PERIOD(P), .DWELL_PERIODS(D), .RAMP_STEP(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .start      (start),
        .abort      (abort),
        .loop       (loop),
        .state      (state),
        .duty       (duty),
        .pwm_out    (pwm_out),
        .period_tick(period_tick),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [11:0] du;
        logic        pwm;
        logic        busy;
        logic        done;
        logic        tick;
    } obs_t;

    obs_t exp_q[$];
    int   base_tab[6] = '{0, 0, P, P, P, 0};
    bit   ramp_tab[6] = '{0, 0, 1, 0, 0, 1};
    int   m_run, m_cnt, m_dwell, m_idx, m_duty, m_pwm, m_done;
    int   checks = 0;
    int   passed = 0;

    // Reference model: profile table, min/max ramp, evaluated on each clock edge
    initial begin
        m_run = 0; m_cnt = 0; m_dwell = 0; m_idx = 0; m_duty = 0; m_pwm = 0; m_done = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            m_done = 0;
            if (!rst_n || abort || !m_run) begin
                m_run = (rst_n && !abort && start) ? 1 : 0;
                m_cnt = 0; m_dwell = 0; m_idx = 0; m_duty = 0;
            end else if (enable) begin
                if (m_cnt == P - 1) begin
                    int b;
                    b = base_tab[m_idx];
                    m_cnt = 0;
                    if (!ramp_tab[m_idx]) m_duty = b;
                    else if (m_duty < b) m_duty = (m_duty + S > b) ? b : m_duty + S;
                    else m_duty = (m_duty - S < b) ? b : m_duty - S;
                    m_dwell++;
                    if (m_dwell == D) begin
                        m_dwell = 0;
                        m_idx++;
                        if (m_idx == 6) begin
                            m_idx = 0;
                            if (!loop) begin
                                m_run = 0; m_duty = 0; m_done = 1;
                            end
                        end
                    end
                end else begin
                    m_cnt++;
                end
            end
            m_pwm = (m_run != 0 && rst_n && enable && m_cnt < m_duty) ? 1 : 0;
        end
    end

    // Expected observation for the current cycle, pushed mid-cycle
    initial forever begin
        obs_t e;
        @(negedge clk);
        e.st = 3'(m_idx);
        e.du = 12'(m_duty);
        e.pwm = m_pwm[0];
        e.busy = m_run[0];
        e.done = m_done[0];
        e.tick = (m_run != 0 && enable && m_cnt == P - 1);
        exp_q.push_back(e);
    end

    // Monitor: pop the expectation and compare against the DUT outputs
    initial forever begin
        obs_t e, a;
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, duty, pwm_out, busy, done, period_tick};
            checks++;
            if (a === e) passed++;
            else $display("FAIL outs t=%0t got st=%0d duty=%0d pwm=%b busy=%b done=%b tick=%b, expected st=%0d duty=%0d pwm=%b busy=%b done=%b tick=%b",
                          $time, a.st, a.du, a.pwm, a.busy, a.done, a.tick, e.st, e.du, e.pwm, e.busy, e.done, e.tick);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit s, input bit a);
        start = s;
        abort = a;
        cyc(1);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_idx(input int idx, input int cnt, input int budget, input string nm);
        int n = 0;
        while (!(m_run != 0 && m_idx == idx && (cnt < 0 || m_cnt == cnt)) && n < budget) begin
            cyc(1);
            n++;
        end
        checks++;
        if (n < budget) passed++;
        else $display("FAIL %s timeout got idx=%0d expected idx=%0d", nm, m_idx, idx);
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while (m_done == 0 && n < budget) begin
            cyc(1);
            n++;
        end
        checks++;
        if (n < budget) passed++;
        else $display("FAIL %s timeout got no done expected done within %0d", nm, budget);
    endtask

    initial begin
        cyc(3);
        rst_n = 1'b1;
        enable = 1'b1;
        cyc(300);
        pulse(1'b1, 1'b1);
        cyc(10);
        pulse(1'b1, 1'b0);
        wait_done(SEQ + 20, "single_run");
        cyc(5);
        loop = 1'b1;
        pulse(1'b1, 1'b0);
        cyc(SEQ + SEQ / 2);
        loop = 1'b0;
        wait_done(SEQ + 20, "loop_run");
        cyc(5);
        pulse(1'b1, 1'b0);
        wait_idx(2, P / 2, SEQ, "reach_freeze");
        enable = 1'b0;
        cyc(100);
        enable = 1'b1;
        wait_idx(3, -1, SEQ, "reach_abort");
        cyc(7);
        pulse(1'b0, 1'b1);
        cyc(20);
        pulse(1'b1, 1'b0);
        wait_idx(2, -1, SEQ, "reach_reset");
        cyc(53);
        #2 rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(5);
        for (int i = 0; i < 20000; i++) begin
            start = ($urandom % 50 == 0);
            abort = ($urandom % 900 == 0);
            if ($urandom % 60 == 0) enable = ~enable;
            if ($urandom % 300 == 0) loop = ~loop;
            if ($urandom % 6000 == 0) begin
                #2 rst_n = 1'b0;
                cyc(2);
                rst_n = 1'b1;
            end
            cyc(1);
        end
        start = 1'b0;
        abort = 1'b0;
        cyc(5);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
